mem_responder: RTL and testbench

Memory-side responder for the datapath's MFA/MFC memory handshake.
- Accepts a request (MFA, RW, address, data type) from the control unit/datapath.
- Performs a big-endian byte, halfword or word access to an internal byte array.
- Inserts a programmable number of wait states, then raises MFC and holds it until MFA is released (4-phase handshake).
- Replaces the zero-latency RAM so control-unit wait loops on MFC are actually exercised.

---
 rtl/mem_responder.sv | 119 +++++++++++
 tb/tb_mem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the MFA/MFC four-phase handshake.
// Big-endian byte/halfword/word access with programmable wait states.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MFA,
    input  logic              RW,
    input  logic [ADDR_W-1:0] Address,
    input  logic [1:0]        Type,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        type_q;
    logic [31:0]       din_q;
    logic [31:0]       rd_data;
    logic [ADDR_W-1:0] a_h;
    logic [ADDR_W-1:0] a_w;

    logic [7:0] Mem [0:2**ADDR_W-1];

    assign a_h = {addr_q[ADDR_W-1:1], 1'b0};
    assign a_w = {addr_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        rd_data = 32'h0;
        case (type_q)
            2'b00: rd_data = {24'h0, Mem[addr_q]};
            2'b01: rd_data = {16'h0, Mem[a_h], Mem[a_h | ADDR_W'(1)]};
            2'b10: rd_data = {Mem[a_w],
                              Mem[a_w | ADDR_W'(1)],
                              Mem[a_w | ADDR_W'(2)],
                              Mem[a_w | ADDR_W'(3)]};
            default: rd_data = 32'h0;
        endcase
    end

    // Storage is never cleared; a reset edge suppresses any pending write.
    always_ff @(posedge CLK) begin
        if (Reset && state == ACCESS && rw_q) begin
            case (type_q)
                2'b00: Mem[addr_q] <= din_q[7:0];
                2'b01: begin
                    Mem[a_h]               <= din_q[15:8];
                    Mem[a_h | ADDR_W'(1)]  <= din_q[7:0];
                end
                2'b10: begin
                    Mem[a_w]               <= din_q[31:24];
                    Mem[a_w | ADDR_W'(1)]  <= din_q[23:16];
                    Mem[a_w | ADDR_W'(2)]  <= din_q[15:8];
                    Mem[a_w | ADDR_W'(3)]  <= din_q[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            MFC     <= 1'b0;
            DataOut <= 32'h0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            type_q  <= 2'b00;
            din_q   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    MFC <= 1'b0;
                    if (MFA) begin
                        rw_q   <= RW;
                        addr_q <= Address;
                        type_q <= Type;
                        din_q  <= DataIn;
                        cnt    <= 4'(WAIT_STATES);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (!MFA) begin
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= ACCESS;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    if (!rw_q) begin
                        DataOut <= rd_data;
                    end
                    MFC   <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    // Holding MFA high parks here; a new request needs a low edge.
                    if (!MFA) begin
                        MFC   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: zero-wait instance for data paths,
// three-wait instance for latency, hold, abort and reset corner cases.
module tb_mem_responder;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        MFA0, MFA3;
    logic        RW;
    logic [7:0]  Address;
    logic [1:0]  Type;
    logic [31:0] DataIn;
    logic [31:0] DataOut0, DataOut3;
    logic        MFC0, MFC3;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
        .CLK(CLK), .Reset(Reset), .MFA(MFA0), .RW(RW),
        .Address(Address), .Type(Type), .DataIn(DataIn),
        .DataOut(DataOut0), .MFC(MFC0)
    );

    mem_responder #(.ADDR_W(8), .WAIT_STATES(3)) dut3 (
        .CLK(CLK), .Reset(Reset), .MFA(MFA3), .RW(RW),
        .Address(Address), .Type(Type), .DataIn(DataIn),
        .DataOut(DataOut3), .MFC(MFC3)
    );

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [1:0]  typ;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic mfc_of(input bit sel);
        return sel ? MFC3 : MFC0;
    endfunction

    task automatic set_mfa(input bit sel, input logic v);
        if (sel) MFA3 = v;
        else     MFA0 = v;
    endtask

    task automatic xact(input bit sel, input logic rw_i,
                        input logic [7:0] a, input logic [1:0] t,
                        input logic [31:0] d, input int lat);
        int n;
        @(negedge CLK);
        RW = rw_i; Address = a; Type = t; DataIn = d;
        set_mfa(sel, 1'b1);
        @(posedge CLK);
        #1;
        Address = a ^ 8'hFF;
        DataIn  = ~d;
        n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while (!mfc_of(sel) && n < 40);
        chk("mfc_latency", 32'(n), 32'(lat));
        @(negedge CLK);
        set_mfa(sel, 1'b0);
        @(posedge CLK); #1;
        chk("mfc_fall", {31'h0, mfc_of(sel)}, 32'h0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h10, 2'b10, 32'hE3A01005, 32'h00000000};
        vecs[1]  = '{1'b0, 8'h10, 2'b10, 32'h0,        32'hE3A01005};
        vecs[2]  = '{1'b0, 8'h11, 2'b00, 32'h0,        32'h000000A0};
        vecs[3]  = '{1'b0, 8'h13, 2'b01, 32'h0,        32'h00001005};
        vecs[4]  = '{1'b1, 8'h21, 2'b01, 32'hFFFFBEEF, 32'h00001005};
        vecs[5]  = '{1'b0, 8'h20, 2'b10, 32'h0,        32'hBEEF0000};
        vecs[6]  = '{1'b0, 8'h10, 2'b11, 32'h0,        32'h00000000};
        vecs[7]  = '{1'b0, 8'h10, 2'b10, 32'h0,        32'hE3A01005};
        vecs[8]  = '{1'b1, 8'h22, 2'b00, 32'h000000AA, 32'hE3A01005};
        vecs[9]  = '{1'b0, 8'h20, 2'b10, 32'h0,        32'hBEEFAA00};
        vecs[10] = '{1'b1, 8'h10, 2'b11, 32'hDEADBEEF, 32'hBEEFAA00};
        vecs[11] = '{1'b0, 8'h12, 2'b01, 32'h0,        32'h00001005};

        Reset = 1'b0; MFA0 = 1'b0; MFA3 = 1'b0;
        RW = 1'b0; Address = 8'h0; Type = 2'b00; DataIn = 32'h0;
        for (int i = 0; i < 256; i++) begin
            dut0.Mem[i] = 8'h00;
            dut3.Mem[i] = 8'h00;
        end
        dut3.Mem[8'h30] = 8'h11; dut3.Mem[8'h31] = 8'h22;
        dut3.Mem[8'h32] = 8'h33; dut3.Mem[8'h33] = 8'h44;
        dut3.Mem[8'h40] = 8'h5A; dut3.Mem[8'h41] = 8'h5B;
        dut3.Mem[8'h42] = 8'h5C; dut3.Mem[8'h43] = 8'h5D;

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_mfc0", {31'h0, MFC0}, 32'h0);
        chk("rst_dout0", DataOut0, 32'h0);
        chk("rst_mfc3", {31'h0, MFC3}, 32'h0);
        chk("rst_dout3", DataOut3, 32'h0);
        @(negedge CLK);
        Reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            xact(1'b0, vecs[i].rw, vecs[i].addr, vecs[i].typ,
                 vecs[i].din, 2);
            chk($sformatf("vec%0d_dout", i), DataOut0, vecs[i].dout);
        end
        chk("mem10", {24'h0, dut0.Mem[8'h10]}, 32'hE3);
        chk("mem13", {24'h0, dut0.Mem[8'h13]}, 32'h05);
        chk("mem20_23", {dut0.Mem[8'h20], dut0.Mem[8'h21],
                         dut0.Mem[8'h22], dut0.Mem[8'h23]}, 32'hBEEFAA00);

        // Three wait states: MFC low for 4 edges, high after the fifth.
        @(negedge CLK);
        RW = 1'b0; Address = 8'h30; Type = 2'b10;
        MFA3 = 1'b1;
        @(posedge CLK);
        for (int e = 1; e <= 4; e++) begin
            @(posedge CLK); #1;
            chk($sformatf("ws3_low_e%0d", e), {31'h0, MFC3}, 32'h0);
        end
        @(posedge CLK); #1;
        chk("ws3_high", {31'h0, MFC3}, 32'h1);
        chk("ws3_dout", DataOut3, 32'h11223344);
        dut3.Mem[8'h30] = 8'h99;
        for (int e = 0; e < 10; e++) begin
            @(posedge CLK); #1;
            chk("ws3_hold_mfc", {31'h0, MFC3}, 32'h1);
        end
        chk("ws3_no_reaccess", DataOut3, 32'h11223344);
        @(negedge CLK);
        MFA3 = 1'b0;
        @(posedge CLK); #1;
        chk("ws3_fall", {31'h0, MFC3}, 32'h0);

        // Abort a word write by dropping MFA mid-WAIT.
        @(negedge CLK);
        RW = 1'b1; Address = 8'h40; Type = 2'b10; DataIn = 32'h12345678;
        MFA3 = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        MFA3 = 1'b0;
        repeat (8) begin
            @(posedge CLK); #1;
            chk("abort_mfc", {31'h0, MFC3}, 32'h0);
        end
        chk("abort_mem", {dut3.Mem[8'h40], dut3.Mem[8'h41],
                          dut3.Mem[8'h42], dut3.Mem[8'h43]}, 32'h5A5B5C5D);
        chk("abort_dout", DataOut3, 32'h11223344);
        xact(1'b1, 1'b0, 8'h40, 2'b10, 32'h0, 5);
        chk("abort_idle_read", DataOut3, 32'h5A5B5C5D);

        // Reset asserted mid-WAIT with MFA still high.
        @(negedge CLK);
        RW = 1'b1; Address = 8'h40; Type = 2'b10; DataIn = 32'h12345678;
        MFA3 = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK); #1;
        chk("rstw_mfc", {31'h0, MFC3}, 32'h0);
        chk("rstw_dout", DataOut3, 32'h0);
        @(negedge CLK);
        MFA3 = 1'b0;
        Reset = 1'b1;
        repeat (8) begin
            @(posedge CLK); #1;
            chk("rstw_mfc_after", {31'h0, MFC3}, 32'h0);
        end
        chk("rstw_mem", {dut3.Mem[8'h40], dut3.Mem[8'h41],
                         dut3.Mem[8'h42], dut3.Mem[8'h43]}, 32'h5A5B5C5D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
